// File: rtl/fsm_phase_monitor.sv
// fsm_phase_monitor: decodes the sequencer's {dout_q, dout_p} pair into phases,
// checks phase order and per-phase length, and counts sequences and errors.
module fsm_phase_monitor #(
    parameter int unsigned PHASE_LEN = 16,
    parameter int unsigned CNT_W     = 6,
    parameter int unsigned SEQ_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_p,
    input  logic             din_q,
    input  logic             clr,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             seq_done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [SEQ_W-1:0] seq_cnt,
    output logic [SEQ_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_PH_P,
        ST_PH_Q,
        ST_PH_PQ
    } state_t;

    localparam logic [CNT_W-1:0] RUN_LEN = CNT_W'(PHASE_LEN);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(PHASE_LEN + 1);
    localparam logic [SEQ_W-1:0] CNT_MAX = '1;
    localparam logic [1:0]       E_ORDER = 2'd1;
    localparam logic [1:0]       E_SHORT = 2'd2;
    localparam logic [1:0]       E_LONG  = 2'd3;

    state_t           r_state;
    logic             r_sv;
    logic [1:0]       r_s_code;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_run;

    state_t           w_next;
    state_t           w_code_state;
    logic [1:0]       w_sc;
    logic [1:0]       w_sc_succ;
    logic [1:0]       w_next_phase;
    logic             w_active;
    logic             w_full;
    logic             w_done;
    logic             w_err;
    logic [1:0]       w_err_code;
    logic [CNT_W-1:0] w_run_next;

    always_comb begin
        if (r_s_code != r_last) begin
            w_run_next = CNT_W'(1);
        end else if (r_run == RUN_MAX) begin
            w_run_next = r_run;
        end else begin
            w_run_next = r_run + CNT_W'(1);
        end
    end

    // Each tracking state corresponds to the code it was entered on, so the
    // legal successor is simply that code plus one (mod 4).
    always_comb begin
        case (r_state)
            ST_PH_P:  w_sc = 2'd1;
            ST_PH_Q:  w_sc = 2'd2;
            ST_PH_PQ: w_sc = 2'd3;
            default:  w_sc = 2'd0;
        endcase
        w_sc_succ = w_sc + 2'd1;
        w_active  = (r_state == ST_PH_P) || (r_state == ST_PH_Q) || (r_state == ST_PH_PQ);
        w_full    = (r_run == RUN_LEN);
        case (r_s_code)
            2'd1:    w_code_state = ST_PH_P;
            2'd2:    w_code_state = ST_PH_Q;
            2'd3:    w_code_state = ST_PH_PQ;
            default: w_code_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_err_code = E_ORDER;
        // r_sv masks the reset value of r_s_code, which is not a real sample.
        if (r_sv) begin
            if (r_state == ST_RESYNC) begin
                if (r_s_code == 2'b00) begin
                    w_next = ST_IDLE;
                end
            end else if (r_s_code == w_sc) begin
                if (w_active && w_full) begin
                    w_err      = 1'b1;
                    w_err_code = E_LONG;
                end
            end else if (r_s_code == w_sc_succ) begin
                if (w_active && !w_full) begin
                    w_err      = 1'b1;
                    w_err_code = E_SHORT;
                end else begin
                    w_done = (r_state == ST_PH_PQ);
                    w_next = w_code_state;
                end
            end else begin
                w_err      = 1'b1;
                w_err_code = E_ORDER;
            end
            if (w_err) begin
                w_next = ST_RESYNC;
            end
        end
    end

    always_comb begin
        case (w_next)
            ST_PH_P:  w_next_phase = 2'd1;
            ST_PH_Q:  w_next_phase = 2'd2;
            ST_PH_PQ: w_next_phase = 2'd3;
            default:  w_next_phase = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RESYNC;
            r_sv     <= 1'b0;
            r_s_code <= '0;
            r_last   <= '0;
            r_run    <= '0;
            locked   <= 1'b0;
            phase    <= '0;
            seq_done <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
            seq_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            r_s_code <= {din_q, din_p};
            r_sv     <= 1'b1;
            if (r_sv) begin
                r_last <= r_s_code;
                r_run  <= w_run_next;
            end
            r_state  <= w_next;
            locked   <= (w_next != ST_RESYNC);
            phase    <= w_next_phase;
            seq_done <= w_done;
            err      <= w_err;
            if (w_err) begin
                err_code <= w_err_code;
            end
            if (clr) begin
                seq_cnt <= '0;
                err_cnt <= '0;
            end else begin
                if (w_done && (seq_cnt != CNT_MAX)) begin
                    seq_cnt <= seq_cnt + SEQ_W'(1);
                end
                if (w_err && (err_cnt != CNT_MAX)) begin
                    err_cnt <= err_cnt + SEQ_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fsm_phase_monitor.sv
// Scoreboard bench for fsm_phase_monitor: a sample-stream reference model pushes
// expected outputs per clock; a monitor process pops and compares them.
module tb_fsm_phase_monitor;

    localparam int unsigned PHASE_LEN = 16;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned SEQ_W     = 2;
    localparam int          CNT_SAT   = (1 << SEQ_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             din_p;
    logic             din_q;
    logic             clr;
    logic             locked;
    logic [1:0]       phase;
    logic             seq_done;
    logic             err;
    logic [1:0]       err_code;
    logic [SEQ_W-1:0] seq_cnt;
    logic [SEQ_W-1:0] err_cnt;

    fsm_phase_monitor #(
        .PHASE_LEN(PHASE_LEN),
        .CNT_W    (CNT_W),
        .SEQ_W    (SEQ_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din_p   (din_p),
        .din_q   (din_q),
        .clr     (clr),
        .locked  (locked),
        .phase   (phase),
        .seq_done(seq_done),
        .err     (err),
        .err_code(err_code),
        .seq_cnt (seq_cnt),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int locked;
        int phase;
        int done;
        int err;
        int code;
        int seq;
        int errc;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: the stream of samples seen so far.
    int m_has_prev;
    int m_prev;
    int m_last;
    int m_run;
    int m_locked;
    int m_seq;
    int m_errc;
    int m_code;

    function automatic void chk(string name, int act, int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp_v, $time);
        end
    endfunction

    task automatic model_reset();
        m_has_prev = 0;
        m_prev     = 0;
        m_last     = 0;
        m_run      = 0;
        m_locked   = 0;
        m_seq      = 0;
        m_errc     = 0;
        m_code     = 0;
    endtask

    // Outputs after the coming edge: judged on the sample taken one edge earlier,
    // with clr taken at the coming edge.
    task automatic model_step(input int c, input int clr_v, output exp_t e);
        int done;
        int ecode;
        int rn;
        int s;
        done  = 0;
        ecode = 0;
        if (m_has_prev != 0) begin
            s  = m_prev;
            rn = (s == m_last) ? ((m_run + 1 > PHASE_LEN + 1) ? PHASE_LEN + 1 : m_run + 1) : 1;
            if (m_locked == 0) begin
                if (s == 0) m_locked = 1;
            end else if (s == m_last) begin
                if (m_last != 0 && rn > PHASE_LEN) ecode = 3;
            end else if (s == (m_last + 1) % 4) begin
                if (m_last != 0 && m_run != PHASE_LEN) ecode = 2;
                else if (m_last == 3) done = 1;
            end else begin
                ecode = 1;
            end
            if (ecode != 0) begin
                m_locked = 0;
                m_code   = ecode;
            end
            m_last = s;
            m_run  = rn;
        end
        if (clr_v != 0) begin
            m_seq  = 0;
            m_errc = 0;
        end else begin
            if (done != 0 && m_seq < CNT_SAT) m_seq++;
            if (ecode != 0 && m_errc < CNT_SAT) m_errc++;
        end
        m_prev     = c;
        m_has_prev = 1;
        e = '{m_locked, (m_locked != 0) ? m_last : 0, done, (ecode != 0) ? 1 : 0,
              m_code, m_seq, m_errc};
    endtask

    task automatic drive(input int c, input int clr_v);
        exp_t e;
        @(negedge clk);
        rst   = 1'b0;
        din_p = c[0];
        din_q = c[1];
        clr   = clr_v[0];
        model_step(c, clr_v, e);
        q.push_back(e);
    endtask

    task automatic do_reset(input int cycles, input int c);
        exp_t e;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst   = 1'b1;
            din_p = c[0];
            din_q = c[1];
            clr   = 1'b0;
            model_reset();
            e = '{0, 0, 0, 0, 0, 0, 0};
            q.push_back(e);
        end
    endtask

    task automatic run_code(input int c, input int n);
        for (int i = 0; i < n; i++) drive(c, 0);
    endtask

    task automatic seq_clean();
        run_code(1, PHASE_LEN);
        run_code(2, PHASE_LEN);
        run_code(3, PHASE_LEN);
        drive(0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("locked",   int'(locked),   e.locked);
                chk("phase",    int'(phase),    e.phase);
                chk("seq_done", int'(seq_done), e.done);
                chk("err",      int'(err),      e.err);
                chk("err_code", int'(err_code), e.code);
                chk("seq_cnt",  int'(seq_cnt),  e.seq);
                chk("err_cnt",  int'(err_cnt),  e.errc);
            end
        end
    end

    initial begin : stimulus
        rst   = 1'b1;
        din_p = 1'b0;
        din_q = 1'b0;
        clr   = 1'b0;
        model_reset();
        do_reset(3, 0);

        // Clean sequence, then a back-to-back one with a single idle sample.
        run_code(0, 3);
        seq_clean();
        seq_clean();
        run_code(0, 3);

        // Short phase.
        run_code(1, PHASE_LEN - 1);
        run_code(2, 1);
        run_code(0, 3);

        // Long phase, then code held during resync.
        run_code(1, PHASE_LEN);
        run_code(2, PHASE_LEN + 4);
        run_code(0, 3);

        // Order errors: 00->10, and 01->11 with a short run.
        run_code(0, 1);
        run_code(2, 1);
        run_code(0, 3);
        run_code(1, 4);
        run_code(3, 1);
        run_code(0, 3);

        // Reset mid-PQ, released with 11 held.
        run_code(1, PHASE_LEN);
        run_code(2, PHASE_LEN);
        run_code(3, 8);
        do_reset(2, 3);
        run_code(3, 5);
        run_code(0, 3);

        // Saturation, then clr coinciding with the 6th completion.
        for (int i = 0; i < 5; i++) seq_clean();
        run_code(1, PHASE_LEN);
        run_code(2, PHASE_LEN);
        run_code(3, PHASE_LEN);
        drive(0, 0);
        drive(0, 1);
        run_code(0, 2);

        // Randomized sequences with occasional faults, clears and resets.
        for (int it = 0; it < 60; it++) begin
            int mode;
            int len;
            int r;
            mode = int'($urandom_range(0, 9));
            if (mode == 0) do_reset(int'($urandom_range(1, 2)), int'($urandom_range(0, 3)));
            r = int'($urandom_range(1, 3));
            for (int k = 0; k < r; k++) drive(0, ($urandom_range(0, 15) == 0) ? 1 : 0);
            for (int ph = 1; ph <= 3; ph++) begin
                len = PHASE_LEN;
                if (mode >= 5) begin
                    r = int'($urandom_range(0, 5));
                    if (r == 0) len = PHASE_LEN - 1;
                    else if (r == 1) len = PHASE_LEN + 1 + int'($urandom_range(0, 2));
                end
                if (mode == 2 && ph == 2) drive(int'($urandom_range(0, 3)), 0);
                for (int k = 0; k < len; k++) drive(ph, ($urandom_range(0, 15) == 0) ? 1 : 0);
            end
        end
        run_code(0, 3);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fsm_phase_monitor.md
# fsm_phase_monitor

Downstream checker for the three-phase output sequencer. Samples the sequencer's `dout_p`/`dout_q` pair and decodes it into phases. Checks that phases appear in the legal order and that each active phase lasts exactly `PHASE_LEN` cycles. Reports completed sequences and protocol errors, with saturating counters for both.

## Interface
- `PHASE_LEN`, 16: required length of each active phase, in clock cycles.
- `CNT_W`, 6: width of the run-length counter. Must hold `PHASE_LEN+1`.
- `SEQ_W`, 8: width of `seq_cnt` and `err_cnt`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `din_p` in 1: connects to sequencer `dout_p`.
- `din_q` in 1: connects to sequencer `dout_q`.
- `clr` in 1: synchronous clear of `seq_cnt` and `err_cnt`.
- `locked` out 1: 1 when the monitor is tracking phases, 0 while resyncing.
- `phase` out 2: current phase. 0 = idle, 1 = P, 2 = Q, 3 = PQ. Forced to 0 while not locked.
- `seq_done` out 1: one-cycle pulse when a full legal sequence completes.
- `err` out 1: one-cycle pulse when an error is detected.
- `err_code` out 2: cause of the last error. 1 = order, 2 = short, 3 = long. Held until the next error.
- `seq_cnt` out SEQ_W: count of completed sequences. Saturates at all-ones.
- `err_cnt` out SEQ_W: count of errors. Saturates at all-ones.

## Operation
- **Input stage.** `code = {din_q, din_p}` is registered every cycle into `s_code` (reset value 0). All checks use `s_code`.
- **States.**
  - RESYNC is the reset state.
  - IDLE, PH_P, PH_Q and PH_PQ are the tracking states.
  - `locked` = 1 in any state except RESYNC.
- **RESYNC.** No checks and no errors. The first sampled code 00 moves to IDLE.
- **Legal transitions.**
  - 00 to 01: enter PH_P.
  - 01 to 10: enter PH_Q.
  - 10 to 11: enter PH_PQ.
  - 11 to 00: return to IDLE.
  - Holding the same code is always legal. IDLE has no length limit.
- **Run counter.**
  - Reloads to 1 on the first sample of each new code.
  - Increments on each repeated sample.
  - Saturates at `PHASE_LEN+1`.
- **Order error (code 1).** Any code change other than the four legal transitions. Order takes priority over length when both apply.
- **Short error (code 2).** Raised on a legal exit from PH_P, PH_Q or PH_PQ when the run count is not equal to `PHASE_LEN`.
- **Long error (code 3).** Raised when the run count would exceed `PHASE_LEN` in PH_P, PH_Q or PH_PQ. It fires on the (`PHASE_LEN+1`)th sample, without waiting for a transition.
- **Any error.** Pulse `err`, update `err_code`, increment `err_cnt`, go to RESYNC.
- **Sequence done.** A legal 11 to 00 exit with run count = `PHASE_LEN` pulses `seq_done`, increments `seq_cnt` and enters IDLE.
- **Clear.**
  - `clr` zeroes both counters in the next cycle.
  - If `clr` coincides with a counting event, the clear wins: the counter reads 0, but the `seq_done`/`err` pulse is still issued.
  - `clr` does not affect state, `phase` or `err_code`.
- **Reset values.** All outputs and registers are 0, and the state is RESYNC. Reset asserted mid-sequence abandons that sequence with no error reported.

## Timing
- **Latency.** A code present at input edge N is in `s_code` after N. The resulting state, `phase`, `locked`, pulses and counters all update at edge N+1, so latency is 2 clocks from the input.
- **Pulses.** `seq_done` and `err` are high for exactly one cycle and are never high in the same cycle.
- **Minimum back-to-back interval.** One idle sample between sequences is enough: 00 sampled once, then 01, is legal.
- **Repeated errors.** No second error is reported until RESYNC has seen 00.
- **Counter wrap.** The run counter never wraps because of saturation. `seq_cnt` and `err_cnt` hold at all-ones.

## Test plan
1. **Clean sequence.** Release reset with 00 for 3 cycles, then 01×16, 10×16, 11×16, 00 → `locked` = 1 two clocks after the first 00; one `seq_done` two clocks after 00 follows 11; `seq_cnt` = 1; `err` never high.
2. **Short phase.** Lock, then 01×15, then 10 → `err` pulse, `err_code` = 2, `err_cnt` = 1, `locked` = 0, `phase` = 0. Then 00 → `locked` = 1 two clocks later.
3. **Long phase.** Lock, then 01×16, then 10 held → `err` pulse with `err_code` = 3 two clocks after the 17th 10 sample; no further error while 10 holds.
4. **Order error.** Lock, then 00 followed directly by 10 → `err_code` = 1. Separately, 01 followed by 11 → `err_code` = 1, which takes priority over the length check.
5. **Reset mid-sequence.** Assert `rst` during PH_PQ; release with input 11 held for 5 cycles, then 00 → no `err`; `locked` = 0 until 00 is seen, then 1.
6. **Saturation and clear.** With `SEQ_W` = 2, run 5 clean sequences → `seq_cnt` = 3. Assert `clr` in the same cycle as the 6th sequence's counting event → `seq_cnt` = 0 and the `seq_done` pulse is still seen.
